// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter between byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       o_start,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_timeout
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, ACCEPT, START, WAIT_DONE, GAP} state_t;

  state_t             state;
  logic [ID_W-1:0]    last;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    idx;
  logic [WD_W-1:0]    wd_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [7:0]         data_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Scan from farthest to nearest so the requester right after 'last' ends up winning.
  always_comb begin
    win = last;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= ID_W'(NUM_REQ - 1);
      wd_cnt     <= '0;
      gap_cnt    <= '0;
      req_ready  <= '0;
      o_start    <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_grant_id <= '0;
      o_timeout  <= 1'b0;
    end else begin
      req_ready <= '0;
      o_start   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state      <= ACCEPT;
            o_busy     <= 1'b1;
            o_grant_id <= win;
            last       <= win;
            o_tx_data  <= data_arr[win];
            req_ready  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          end
        end
        ACCEPT: begin
          state   <= START;
          o_start <= 1'b1;
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done arriving on the last allowed cycle still counts as a normal completion.
          if (i_tx_done) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end
          end else if (wd_cnt == WD_LAST) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
